// File: rtl/can_crc_pkg.sv
// Shared constants, state/owner encodings and the CRC-15 bit step for the CAN CRC arbiter.
package can_crc_pkg;

    localparam int CRC_W      = 15;
    localparam int FRAME_W    = 83;
    localparam int HDR_W      = 19;
    localparam int MAX_DATA_W = 64;
    localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam logic OWNER_TX = 1'b0;
    localparam logic OWNER_RX = 1'b1;

    // One MSB-first shift of the CAN CRC-15 register.
    function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc,
                                                    input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[CRC_W-1];
        return fb ? ({crc[CRC_W-2:0], 1'b0} ^ CRC_POLY) : {crc[CRC_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/CRC15_D83.sv
// Combinational CAN CRC-15 over an 83-bit word, MSB first, initial value zero.
module CRC15_D83
    import can_crc_pkg::*;
(
    input  logic [FRAME_W-1:0] data,
    output logic [CRC_W-1:0]   crc
);

    // Unrolled bit-serial CRC; leading zeros leave the register at zero.
    always_comb begin
        crc = 15'h0000;
        for (int i = FRAME_W - 1; i >= 0; i--) begin
            crc = crc15_step(crc, data[i]);
        end
    end

endmodule

// File: rtl/can_crc_arbiter.sv
// Round-robin TX/RX arbiter around a shared CAN CRC-15 engine.
// Optional received-CRC compare is enabled by defining CAN_CRC_ARBITER_CHECK_EN.
module can_crc_arbiter
    import can_crc_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_req,
    input  logic                rx_req,
    input  logic [FRAME_W-1:0]  tx_frame,
    input  logic [FRAME_W-1:0]  rx_frame,
    input  logic [3:0]          tx_dlc,
    input  logic [3:0]          rx_dlc,
    input  logic                tx_rtr,
    input  logic                rx_rtr,
    input  logic                tx_ack,
    input  logic                rx_ack,
`ifdef CAN_CRC_ARBITER_CHECK_EN
    input  logic [CRC_W-1:0]    rx_crc_rcv,
    output logic                crc_match,
`endif
    output logic                tx_gnt,
    output logic                rx_gnt,
    output logic                tx_done,
    output logic                rx_done,
    output logic [CRC_W-1:0]    crc_out,
    output logic                crc_owner
);

    state_e               state;
    logic                 prio;
    logic [FRAME_W-1:0]   frame_r;
    logic [3:0]           dlc_r;
    logic                 rtr_r;
    logic [FRAME_W-1:0]   engine_in;
    logic [CRC_W-1:0]     engine_out;
    logic [6:0]           data_bits;
    logic                 winner;
    logic                 owner_ack;
`ifdef CAN_CRC_ARBITER_CHECK_EN
    logic [CRC_W-1:0]     rcv_r;
`endif

    // Number of data bits that follow the header; dlc above 8 counts as 8.
    always_comb begin
        if (rtr_r) begin
            data_bits = 7'd0;
        end else if (dlc_r >= 4'd8) begin
            data_bits = 7'd64;
        end else begin
            data_bits = {1'b0, dlc_r[2:0], 3'b000};
        end
    end

    // Arbitration winner: the priority holder on a tie, otherwise whoever asks.
    always_comb begin
        if (tx_req && rx_req) begin
            winner = prio;
        end else if (rx_req) begin
            winner = OWNER_RX;
        end else begin
            winner = OWNER_TX;
        end
    end

    // Only the current owner may release the result.
    always_comb begin
        if (crc_owner == OWNER_RX) begin
            owner_ack = rx_ack;
        end else begin
            owner_ack = tx_ack;
        end
    end

    CRC15_D83 u_engine (
        .data (engine_in),
        .crc  (engine_out)
    );

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= RR_INIT;
            tx_gnt    <= 1'b0;
            rx_gnt    <= 1'b0;
            tx_done   <= 1'b0;
            rx_done   <= 1'b0;
            crc_out   <= 15'h0000;
            crc_owner <= OWNER_TX;
            frame_r   <= {FRAME_W{1'b0}};
            dlc_r     <= 4'd0;
            rtr_r     <= 1'b0;
            engine_in <= {FRAME_W{1'b0}};
`ifdef CAN_CRC_ARBITER_CHECK_EN
            rcv_r     <= 15'h0000;
            crc_match <= 1'b0;
`endif
        end else begin
            tx_gnt <= 1'b0;
            rx_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_req || rx_req) begin
                        state     <= LOAD;
                        crc_owner <= winner;
                        prio      <= ~winner;
                        tx_gnt    <= ~winner;
                        rx_gnt    <= winner;
                        frame_r   <= winner ? rx_frame : tx_frame;
                        dlc_r     <= winner ? rx_dlc : tx_dlc;
                        rtr_r     <= winner ? rx_rtr : tx_rtr;
`ifdef CAN_CRC_ARBITER_CHECK_EN
                        rcv_r     <= rx_crc_rcv;
`endif
                    end
                end
                LOAD: begin
                    // Right-align the used bits; zero MSBs do not disturb a zero-seeded CRC.
                    engine_in <= frame_r >> (7'd64 - data_bits);
                    state     <= CALC;
                end
                CALC: begin
                    crc_out <= engine_out;
`ifdef CAN_CRC_ARBITER_CHECK_EN
                    crc_match <= (crc_owner == OWNER_RX) && (engine_out == rcv_r);
`endif
                    state   <= HOLD;
                end
                HOLD: begin
                    if ((tx_done || rx_done) && owner_ack) begin
                        tx_done <= 1'b0;
                        rx_done <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tx_done <= (crc_owner == OWNER_TX);
                        rx_done <= (crc_owner == OWNER_RX);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_crc_arbiter.sv
// Scoreboard bench for can_crc_arbiter; expected CRCs come from a bit-serial model.
module tb_can_crc_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_req = 1'b0, rx_req = 1'b0;
    logic [82:0] tx_frame = '0, rx_frame = '0;
    logic [3:0]  tx_dlc = '0, rx_dlc = '0;
    logic        tx_rtr = 1'b0, rx_rtr = 1'b0;
    logic        tx_ack = 1'b0, rx_ack = 1'b0;
    logic        tx_gnt, rx_gnt, tx_done, rx_done, crc_owner;
    logic [14:0] crc_out;
`ifdef CAN_CRC_ARBITER_CHECK_EN
    logic [14:0] rx_crc_rcv = '0;
    logic        crc_match;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        owner;
        logic [14:0] crc;
    } exp_t;
    exp_t sb[$];

    can_crc_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .tx_req(tx_req), .rx_req(rx_req),
        .tx_frame(tx_frame), .rx_frame(rx_frame),
        .tx_dlc(tx_dlc), .rx_dlc(rx_dlc),
        .tx_rtr(tx_rtr), .rx_rtr(rx_rtr),
        .tx_ack(tx_ack), .rx_ack(rx_ack),
`ifdef CAN_CRC_ARBITER_CHECK_EN
        .rx_crc_rcv(rx_crc_rcv), .crc_match(crc_match),
`endif
        .tx_gnt(tx_gnt), .rx_gnt(rx_gnt),
        .tx_done(tx_done), .rx_done(rx_done),
        .crc_out(crc_out), .crc_owner(crc_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] model_crc(input logic [82:0] f, input logic [3:0] dlc,
                                              input logic rtr);
        int db;
        logic [14:0] c;
        logic fb;
        db = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
        c = 15'h0000;
        for (int i = 82; i >= 64 - db; i--) begin
            fb = f[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    function automatic logic [82:0] rand_frame();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[82:0];
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single request: push expectation at drive time, return what the DUT showed.
    task automatic do_txn(input logic who, input logic [82:0] f, input logic [3:0] dlc,
                          input logic rtr, input logic [14:0] rcv,
                          output logic gnt_ok, output int lat, output logic [14:0] crc,
                          output logic own, output logic done_fell, output logic match);
        exp_t e;
        @(negedge clk);
        if (who) begin
            rx_req = 1'b1; rx_frame = f; rx_dlc = dlc; rx_rtr = rtr;
        end else begin
            tx_req = 1'b1; tx_frame = f; tx_dlc = dlc; tx_rtr = rtr;
        end
`ifdef CAN_CRC_ARBITER_CHECK_EN
        rx_crc_rcv = rcv;
`else
        if (rcv != 15'h0000) e.crc = rcv;
`endif
        e.owner = who;
        e.crc = model_crc(f, dlc, rtr);
        sb.push_back(e);
        @(posedge clk); #1;
        gnt_ok = who ? (rx_gnt && !tx_gnt) : (tx_gnt && !rx_gnt);
        tx_req = 1'b0; rx_req = 1'b0;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            lat++;
            if (tx_done || rx_done) break;
        end
        crc = crc_out;
        own = crc_owner;
`ifdef CAN_CRC_ARBITER_CHECK_EN
        match = crc_match;
`else
        match = 1'b0;
`endif
        if (who) rx_ack = 1'b1; else tx_ack = 1'b1;
        @(posedge clk); #1;
        tx_ack = 1'b0; rx_ack = 1'b0;
        done_fell = !(tx_done || rx_done);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({tx_gnt, rx_gnt, tx_done, rx_done, crc_out, crc_owner} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b done=%b%b crc=%h own=%b, want all 0",
                     tx_gnt, rx_gnt, tx_done, rx_done, crc_out, crc_owner);
        end
    endtask

    task automatic test_zero_frame();
        logic g, own, fell, m; int lat; logic [14:0] crc; exp_t e;
        do_txn(1'b0, 83'h0, 4'd0, 1'b0, 15'h0, g, lat, crc, own, fell, m);
        e = sb.pop_front();
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL zero_gnt: got %b want 1", g); end
        checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", lat); end
        checks++; if (crc !== e.crc) begin errors++; $display("FAIL zero_crc: got %h want %h", crc, e.crc); end
        checks++; if (own !== e.owner) begin errors++; $display("FAIL zero_owner: got %b want %b", own, e.owner); end
        checks++; if (fell !== 1'b1) begin errors++; $display("FAIL zero_done_fall: done still high"); end
    endtask

    task automatic test_single_bit();
        logic g, own, fell, m; int lat; logic [14:0] crc; exp_t e; logic [82:0] f;
        f = '0; f[64] = 1'b1;
        do_txn(1'b1, f, 4'd0, 1'b0, 15'h4599, g, lat, crc, own, fell, m);
        e = sb.pop_front();
        checks++; if (crc !== 15'h4599 || crc !== e.crc) begin errors++; $display("FAIL single_crc: got %h want 4599", crc); end
        checks++; if (own !== 1'b1 || g !== 1'b1) begin errors++; $display("FAIL single_owner: got own=%b gnt=%b want 1/1", own, g); end
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", lat); end
`ifdef CAN_CRC_ARBITER_CHECK_EN
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL match_hit: got %b want 1", m); end
        do_txn(1'b1, f, 4'd0, 1'b0, 15'h4598, g, lat, crc, own, fell, m);
        e = sb.pop_front();
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL match_miss: got %b want 0", m); end
`endif
    endtask

    task automatic test_clamp_rtr();
        logic g, own, fell, m; int lat; logic [14:0] c8, c12, cr, c0; exp_t e; logic [82:0] f;
        f = rand_frame();
        do_txn(1'b0, f, 4'd8, 1'b0, 15'h0, g, lat, c8, own, fell, m);
        e = sb.pop_front();
        checks++; if (c8 !== e.crc) begin errors++; $display("FAIL dlc8_crc: got %h want %h", c8, e.crc); end
        do_txn(1'b1, f, 4'd12, 1'b0, 15'h0, g, lat, c12, own, fell, m);
        e = sb.pop_front();
        checks++; if (c12 !== e.crc || c12 !== c8) begin errors++; $display("FAIL dlc12_crc: got %h want %h", c12, e.crc); end
        do_txn(1'b0, f, 4'd8, 1'b1, 15'h0, g, lat, cr, own, fell, m);
        e = sb.pop_front();
        checks++; if (cr !== e.crc) begin errors++; $display("FAIL rtr_crc: got %h want %h", cr, e.crc); end
        do_txn(1'b0, f, 4'd0, 1'b0, 15'h0, g, lat, c0, own, fell, m);
        e = sb.pop_front();
        checks++; if (c0 !== e.crc || c0 !== cr) begin errors++; $display("FAIL dlc0_crc: got %h want %h", c0, e.crc); end
    endtask

    task automatic test_random();
        logic g, own, fell, m; int lat; logic [14:0] crc; exp_t e; logic who; logic [3:0] dlc; logic rtr;
        for (int n = 0; n < 8; n++) begin
            who = 1'($urandom_range(0, 1));
            dlc = 4'($urandom_range(0, 15));
            rtr = ($urandom_range(0, 3) == 0);
            do_txn(who, rand_frame(), dlc, rtr, 15'h0, g, lat, crc, own, fell, m);
            e = sb.pop_front();
            checks++;
            if (crc !== e.crc || own !== e.owner) begin
                errors++;
                $display("FAIL random_%0d: got crc=%h own=%b want crc=%h own=%b", n, crc, own, e.crc, e.owner);
            end
        end
    endtask

    task automatic test_arbitration();
        exp_t e; int wait_n; logic gown;
        rst = 1'b1;
        tx_frame = rand_frame(); tx_dlc = 4'd3; tx_rtr = 1'b0;
        rx_frame = rand_frame(); rx_dlc = 4'd6; rx_rtr = 1'b0;
        tx_req = 1'b1; rx_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int gi = 0; gi < 3; gi++) begin
            wait_n = 0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                wait_n++;
                if (tx_gnt || rx_gnt) break;
            end
            gown = rx_gnt;
            e.owner = 1'(gi % 2);
            e.crc = e.owner ? model_crc(rx_frame, rx_dlc, rx_rtr) : model_crc(tx_frame, tx_dlc, tx_rtr);
            sb.push_back(e);
            checks++;
            if (gown !== e.owner || tx_gnt === rx_gnt) begin
                errors++; $display("FAIL rr_order_%0d: got tx_gnt=%b rx_gnt=%b want owner %b", gi, tx_gnt, rx_gnt, e.owner);
            end
            checks++;
            if (wait_n != 1) begin errors++; $display("FAIL b2b_gap_%0d: got %0d edges want 1", gi, wait_n); end
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (tx_done || rx_done) break;
            end
            if (e.owner == 1'b0) begin
                rx_ack = 1'b1;
                @(posedge clk); #1;
                rx_ack = 1'b0;
                checks++;
                if (tx_done !== 1'b1) begin errors++; $display("FAIL nonowner_ack: tx_done got %b want 1", tx_done); end
            end
            e = sb.pop_front();
            checks++;
            if (crc_out !== e.crc || crc_owner !== e.owner) begin
                errors++; $display("FAIL rr_crc_%0d: got %h/%b want %h/%b", gi, crc_out, crc_owner, e.crc, e.owner);
            end
            if (e.owner) rx_ack = 1'b1; else tx_ack = 1'b1;
            @(posedge clk); #1;
            tx_ack = 1'b0; rx_ack = 1'b0;
            if (gi == 2) begin tx_req = 1'b0; rx_req = 1'b0; end
            checks++;
            if (tx_done || rx_done) begin errors++; $display("FAIL rr_done_fall_%0d: done got %b%b want 00", gi, tx_done, rx_done); end
        end
    endtask

    task automatic test_mid_reset();
        logic g, own, fell, m; int lat; logic [14:0] crc; exp_t e; logic seen;
        @(negedge clk);
        tx_req = 1'b1; tx_frame = rand_frame(); tx_dlc = 4'd4;
        @(posedge clk); #1;
        tx_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++;
        if (tx_done || rx_done || crc_out !== 15'h0) begin
            errors++; $display("FAIL midrst_clear: got done=%b%b crc=%h want 0", tx_done, rx_done, crc_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_done || rx_done || tx_gnt || rx_gnt) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_quiet: got activity after reset, want none"); end
        do_txn(1'b1, rand_frame(), 4'd5, 1'b0, 15'h0, g, lat, crc, own, fell, m);
        e = sb.pop_front();
        checks++;
        if (crc !== e.crc || lat != 3 || g !== 1'b1) begin
            errors++; $display("FAIL midrst_resume: got crc=%h lat=%0d gnt=%b want crc=%h lat=3 gnt=1", crc, lat, g, e.crc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single_bit();
        test_clamp_rtr();
        test_random();
        test_arbitration();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
